instr_reg_sched: RTL and testbench
==================================

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

Interface
REQ-001 Parameter DEPTH, default 32: number of instruction register entries, power of two, 2 to 256.
REQ-002 Parameter OPCODE_W, default 4: opcode width.
REQ-003 Parameter OPERAND_W, default 32: operand width, two's-complement.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  2  per-requester write request; bit i belongs to requester i.
REQ-007 req_opcode0/req_opcode1  input  OPCODE_W each  opcode per requester.
REQ-008 req_operand_a0/a1, req_operand_b0/b1  input  OPERAND_W each  operands per requester.
REQ-009 req_ready  output  2  per-requester grant; a write transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 flush  input  1  discard all stored instructions and reinitialise the register.
REQ-011 rd_ready  input  1  consumer accepts the instruction currently addressed by read_pointer.
REQ-012 rd_valid  output  1  an unread instruction is present at read_pointer.
REQ-013 load_en, opcode, operand_a, operand_b, write_pointer  output  1/OPCODE_W/OPERAND_W/OPERAND_W/log2(DEPTH)  write port toward the instruction register.
REQ-014 read_pointer  output  log2(DEPTH)  read address toward the instruction register.
REQ-015 dut_reset_n  output  1  active-low reset driven to the instruction register.
REQ-016 count  output  log2(DEPTH)+1  number of written, unread entries.

Function
REQ-017 FSM states: INIT and RUN. INIT drives dut_reset_n=0 for exactly 2 cycles, then moves to RUN. dut_reset_n=1 in RUN.
REQ-018 In INIT, req_ready=0, rd_valid=0, load_en=0.
REQ-019 In RUN, flush=1 moves the FSM to INIT on the next edge; pointers and count clear to 0; any same-cycle write or read handshake is discarded.
REQ-020 Arbitration is round-robin between the two requesters; a last-grant bit toggles only on an accepted transfer. After reset, requester 0 has priority.
REQ-021 Only one req_ready bit may be high per cycle. A grant is offered only to an asserting requester, and only when count + load_en < DEPTH.
REQ-022 Write latency is 1 cycle: a transfer at edge N sets load_en=1 with the registered opcode, operands and write_pointer during cycle N+1.
REQ-023 write_pointer advances by 1 at the edge that ends a load_en=1 cycle, wrapping from DEPTH-1 to 0.
REQ-024 rd_valid = (state==RUN) and (count>0).
REQ-025 On rd_valid and rd_ready, read_pointer advances by 1 (wrapping DEPTH-1 to 0) and count decrements.
REQ-026 count increments at each edge ending a load_en=1 cycle; simultaneous increment and decrement leaves count unchanged.
REQ-027 When count==DEPTH, req_ready=0. When count==0, rd_valid=0 even if load_en=1 in the same cycle (no write-to-read bypass).
REQ-028 Operand and opcode values pass through unmodified; no arithmetic is applied to them.

Reset
REQ-029 On reset=1 at a rising edge: state=INIT with a 2-cycle INIT counter restarted, write_pointer=0, read_pointer=0, count=0, load_en=0, opcode/operands=0, last-grant=requester 1 (so requester 0 wins next), statistics=0.
REQ-030 Reset asserted mid-transfer discards any pending load_en cycle; reset dominates flush.

Configuration
REQ-031 Macro INSTR_REG_SCHED_STATS_EN. When defined, add outputs wr_total and rd_total (16 bits each). They count accepted writes and reads, saturate at 0xFFFF, and are cleared by reset but not by flush. When undefined, these ports and counters do not exist and all other behaviour is identical.

Verification
REQ-032 Reset, then idle: dut_reset_n=0 for 2 cycles, then 1; count=0, rd_valid=0, req_ready=00 with req_valid=00.
REQ-033 Both requesters are valid continuously for 4 transfers: grants alternate 0,1,0,1; load_en follows each grant by 1 cycle at write_pointer 0,1,2,3; count reaches 4.
REQ-034 Write 32 entries (DEPTH=32) with rd_ready=0: req_ready drops after 32 transfers; write_pointer wraps to 0; count=32.
REQ-035 count=5, then one write and one read in the same cycle: count stays 5, and read_pointer and write_pointer each advance by 1.
REQ-036 flush at count=3 with a concurrent transfer: that transfer produces no load_en; INIT lasts 2 cycles; pointers and count are 0.
REQ-037 With INSTR_REG_SCHED_STATS_EN defined, 10 writes and 4 reads: wr_total=10, rd_total=4; after flush both are unchanged; after reset both are 0.

Source files
------------

// File: rtl/instr_reg_sched.sv
// Instruction register write/read scheduler.
// Arbitrates two requesters (round-robin) into a single registered write port
// toward an instruction register, tracks occupancy and drives the read address.
// A two-cycle INIT phase holds the register in reset (dut_reset_n low) after
// reset or flush.
// Optional statistics (wr_total / rd_total) are built when the macro
// INSTR_REG_SCHED_STATS_EN is defined.

module instr_reg_sched #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned OPCODE_W  = 4,
    parameter int unsigned OPERAND_W = 32,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [OPCODE_W-1:0]  req_opcode0,
    input  logic [OPCODE_W-1:0]  req_opcode1,
    input  logic [OPERAND_W-1:0] req_operand_a0,
    input  logic [OPERAND_W-1:0] req_operand_a1,
    input  logic [OPERAND_W-1:0] req_operand_b0,
    input  logic [OPERAND_W-1:0] req_operand_b1,
    output logic [1:0]           req_ready,
    input  logic                 flush,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic                 load_en,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic [AW-1:0]        write_pointer,
    output logic [AW-1:0]        read_pointer,
    output logic                 dut_reset_n,
`ifdef INSTR_REG_SCHED_STATS_EN
    output logic [15:0]          wr_total,
    output logic [15:0]          rd_total,
`endif
    output logic [CW-1:0]        count
);

    localparam logic StInit = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                 state_q, state_d;
    logic                 init_cnt_q, init_cnt_d;
    logic [AW-1:0]        wp_q, wp_d;
    logic [AW-1:0]        rp_q, rp_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 load_en_q, load_en_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic [OPERAND_W-1:0] operand_a_q, operand_a_d;
    logic [OPERAND_W-1:0] operand_b_q, operand_b_d;
    // 1: requester 1 was granted last, so requester 0 wins a tie next.
    logic                 last_q, last_d;

    logic                 running;
    logic                 has_room;
    logic [CW:0]          occupancy;
    logic [1:0]           grant;
    logic                 wr_fire;
    logic                 rd_fire;

    assign running   = (state_q == StRun);
    // An in-flight load_en cycle already owns a slot.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(load_en_q);
    assign has_room  = (occupancy < (CW + 1)'(DEPTH));
    assign rd_valid  = running && (count_q != '0);
    assign rd_fire   = rd_valid && rd_ready;
    assign wr_fire   = |grant;

    // Round-robin grant, offered only to an asserting requester with space available.
    always_comb begin
        grant = 2'b00;
        if (running && has_room) begin
            if (req_valid[0] && (!req_valid[1] || last_q)) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
    end

    assign req_ready = grant;

    // Next-state logic for FSM, pointers, occupancy and the write-port register.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        load_en_d   = 1'b0;
        opcode_d    = opcode_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        last_d      = last_q;

        if (flush) begin
            // Flush drops any same-cycle handshake and restarts the INIT phase.
            state_d    = StInit;
            init_cnt_d = 1'b0;
            wp_d       = '0;
            rp_d       = '0;
            count_d    = '0;
        end else if (!running) begin
            if (init_cnt_q) begin
                state_d    = StRun;
                init_cnt_d = 1'b0;
            end else begin
                init_cnt_d = 1'b1;
            end
        end else begin
            load_en_d = wr_fire;
            if (wr_fire) begin
                last_d = grant[1];
                if (grant[1]) begin
                    opcode_d    = req_opcode1;
                    operand_a_d = req_operand_a1;
                    operand_b_d = req_operand_b1;
                end else begin
                    opcode_d    = req_opcode0;
                    operand_a_d = req_operand_a0;
                    operand_b_d = req_operand_b0;
                end
            end
            if (load_en_q) begin
                wp_d = wp_q + AW'(1);
            end
            if (rd_fire) begin
                rp_d = rp_q + AW'(1);
            end
            case ({load_en_q, rd_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset dominates flush and drops any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInit;
            init_cnt_q  <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            load_en_q   <= 1'b0;
            opcode_q    <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            load_en_q   <= load_en_d;
            opcode_q    <= opcode_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            last_q      <= last_d;
        end
    end

    assign load_en       = load_en_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign write_pointer = wp_q;
    assign read_pointer  = rp_q;
    assign count         = count_q;
    assign dut_reset_n   = running;

`ifdef INSTR_REG_SCHED_STATS_EN
    logic [15:0] wr_total_q, rd_total_q;

    // Saturating transfer counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_total_q <= '0;
            rd_total_q <= '0;
        end else begin
            if (wr_fire && !flush && (wr_total_q != 16'hFFFF)) begin
                wr_total_q <= wr_total_q + 16'd1;
            end
            if (rd_fire && !flush && (rd_total_q != 16'hFFFF)) begin
                rd_total_q <= rd_total_q + 16'd1;
            end
        end
    end

    assign wr_total = wr_total_q;
    assign rd_total = rd_total_q;
`endif

endmodule

// File: tb/tb_instr_reg_sched.sv
// Self-checking bench for instr_reg_sched (DEPTH=32, OPCODE_W=4, OPERAND_W=32).
// Table-driven reset/arbitration vectors followed by hand-written sequences for
// fill-to-full, concurrent read/write, flush, reset-mid-transfer and statistics.

module tb_instr_reg_sched;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [3:0]  req_opcode0, req_opcode1;
    logic [31:0] req_operand_a0, req_operand_a1, req_operand_b0, req_operand_b1;
    logic [1:0]  req_ready;
    logic        flush, rd_ready, rd_valid, load_en, dut_reset_n;
    logic [3:0]  opcode;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  write_pointer, read_pointer;
    logic [5:0]  count;
`ifdef INSTR_REG_SCHED_STATS_EN
    logic [15:0] wr_total, rd_total;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_reg_sched #(
        .DEPTH     (DEPTH),
        .OPCODE_W  (4),
        .OPERAND_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_opcode0    (req_opcode0),
        .req_opcode1    (req_opcode1),
        .req_operand_a0 (req_operand_a0),
        .req_operand_a1 (req_operand_a1),
        .req_operand_b0 (req_operand_b0),
        .req_operand_b1 (req_operand_b1),
        .req_ready      (req_ready),
        .flush          (flush),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .load_en        (load_en),
        .opcode         (opcode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .write_pointer  (write_pointer),
        .read_pointer   (read_pointer),
        .dut_reset_n    (dut_reset_n),
`ifdef INSTR_REG_SCHED_STATS_EN
        .wr_total       (wr_total),
        .rd_total       (rd_total),
`endif
        .count          (count)
    );

    typedef struct packed {
        logic [1:0]  rv;
        logic        rdr;
        logic [3:0]  op0;
        logic [3:0]  op1;
        logic        e_rstn;
        logic [1:0]  e_rr;
        logic        e_rdv;
        logic        e_ld;
        logic        e_data;
        logic [3:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [4:0]  e_wp;
        logic [4:0]  e_rp;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands are derived from the opcode so each transfer carries distinct data.
    task automatic drive_ops(input logic [3:0] o0, input logic [3:0] o1);
        req_opcode0    = o0;
        req_opcode1    = o1;
        req_operand_a0 = {8'hA0, 20'h0, o0};
        req_operand_b0 = {8'hB0, 20'h0, o0};
        req_operand_a1 = {8'hA1, 20'h0, o1};
        req_operand_b1 = {8'hB1, 20'h0, o1};
    endtask

    // Leaves the DUT at the first RUN cycle.
    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; req_valid = 2'b00; rd_ready = 1'b0;
        drive_ops(4'h0, 4'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 2'b01;
            drive_ops(4'(i), 4'h0);
            tick();
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        int nxfer;

        // Reset, idle, then four alternating transfers.
        vecs[0] = '{2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0,
                    1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 6'd0};
        vecs[1] = '{2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0,
                    1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 6'd0};
        vecs[2] = '{2'b00, 1'b0, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0,
                    1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 6'd0};
        vecs[3] = '{2'b11, 1'b0, 4'h1, 4'h2, 1'b1, 2'b01, 1'b0, 1'b0,
                    1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 6'd0};
        vecs[4] = '{2'b11, 1'b0, 4'h3, 4'h4, 1'b1, 2'b10, 1'b0, 1'b1,
                    1'b1, 4'h1, 32'hA000_0001, 32'hB000_0001, 5'd0, 5'd0, 6'd0};
        vecs[5] = '{2'b11, 1'b0, 4'h5, 4'h6, 1'b1, 2'b01, 1'b1, 1'b1,
                    1'b1, 4'h4, 32'hA100_0004, 32'hB100_0004, 5'd1, 5'd0, 6'd1};
        vecs[6] = '{2'b11, 1'b0, 4'h7, 4'h8, 1'b1, 2'b10, 1'b1, 1'b1,
                    1'b1, 4'h5, 32'hA000_0005, 32'hB000_0005, 5'd2, 5'd0, 6'd2};
        vecs[7] = '{2'b00, 1'b0, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b1,
                    1'b1, 4'h8, 32'hA100_0008, 32'hB100_0008, 5'd3, 5'd0, 6'd3};
        vecs[8] = '{2'b00, 1'b0, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b0,
                    1'b0, 4'h0, 32'h0, 32'h0, 5'd4, 5'd0, 6'd4};

        reset = 1'b1; flush = 1'b0; req_valid = 2'b00; rd_ready = 1'b0;
        drive_ops(4'h0, 4'h0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            req_valid = vecs[i].rv;
            rd_ready  = vecs[i].rdr;
            drive_ops(vecs[i].op0, vecs[i].op1);
            @(negedge clk);
            check($sformatf("v%0d dut_reset_n", i), 64'(dut_reset_n), 64'(vecs[i].e_rstn));
            check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_rr));
            check($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_rdv));
            check($sformatf("v%0d load_en", i), 64'(load_en), 64'(vecs[i].e_ld));
            check($sformatf("v%0d write_pointer", i), 64'(write_pointer), 64'(vecs[i].e_wp));
            check($sformatf("v%0d read_pointer", i), 64'(read_pointer), 64'(vecs[i].e_rp));
            check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_data) begin
                check($sformatf("v%0d opcode", i), 64'(opcode), 64'(vecs[i].e_op));
                check($sformatf("v%0d operand_a", i), 64'(operand_a), 64'(vecs[i].e_a));
                check($sformatf("v%0d operand_b", i), 64'(operand_b), 64'(vecs[i].e_b));
            end
            tick();
        end

        // Fill to DEPTH with no reads: exactly DEPTH grants, pointer wraps.
        do_reset();
        nxfer = 0;
        req_valid = 2'b01;
        for (int i = 0; i < DEPTH + 8; i++) begin
            drive_ops(4'(i), 4'h0);
            @(negedge clk);
            if (req_ready[0]) nxfer++;
            tick();
        end
        @(negedge clk);
        check("full transfers", 64'(nxfer), 64'(DEPTH));
        check("full req_ready", 64'(req_ready), 64'd0);
        check("full count", 64'(count), 64'(DEPTH));
        check("full write_pointer", 64'(write_pointer), 64'd0);
        check("full rd_valid", 64'(rd_valid), 64'd1);
        req_valid = 2'b00;
        tick();

        // count=5, then a load_en cycle coinciding with a read.
        do_reset();
        write_n(5);
        @(negedge clk);
        check("rw count5", 64'(count), 64'd5);
        req_valid = 2'b01;
        drive_ops(4'hC, 4'h0);
        tick();
        req_valid = 2'b00;
        rd_ready  = 1'b1;
        @(negedge clk);
        check("rw load_en", 64'(load_en), 64'd1);
        check("rw opcode", 64'(opcode), 64'hC);
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        check("rw count", 64'(count), 64'd5);
        check("rw read_pointer", 64'(read_pointer), 64'd1);
        check("rw write_pointer", 64'(write_pointer), 64'd6);

        // Flush at count=3 with a concurrent transfer.
        do_reset();
        write_n(3);
        req_valid = 2'b01;
        flush     = 1'b1;
        @(negedge clk);
        check("flush pre count", 64'(count), 64'd3);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush load_en", 64'(load_en), 64'd0);
        check("flush init1 rstn", 64'(dut_reset_n), 64'd0);
        check("flush init req_ready", 64'(req_ready), 64'd0);
        check("flush write_pointer", 64'(write_pointer), 64'd0);
        check("flush read_pointer", 64'(read_pointer), 64'd0);
        check("flush count", 64'(count), 64'd0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("flush init2 rstn", 64'(dut_reset_n), 64'd0);
        tick();
        @(negedge clk);
        check("flush run rstn", 64'(dut_reset_n), 64'd1);
        check("flush run rd_valid", 64'(rd_valid), 64'd0);

        // Reset on the edge of a transfer discards the pending load.
        req_valid = 2'b01;
        flush     = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("rst load_en", 64'(load_en), 64'd0);
        check("rst rstn", 64'(dut_reset_n), 64'd0);
        check("rst count", 64'(count), 64'd0);
        tick();
        tick();

`ifdef INSTR_REG_SCHED_STATS_EN
        // Statistics: 10 writes, 4 reads; flush keeps them, reset clears them.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            drive_ops(4'(i), 4'(i + 1));
            tick();
        end
        req_valid = 2'b00;
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_ready = 1'b0;
        @(negedge clk);
        check("stats wr_total", 64'(wr_total), 64'd10);
        check("stats rd_total", 64'(rd_total), 64'd4);
        check("stats count", 64'(count), 64'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("stats flush wr_total", 64'(wr_total), 64'd10);
        check("stats flush rd_total", 64'(rd_total), 64'd4);
        do_reset();
        @(negedge clk);
        check("stats reset wr_total", 64'(wr_total), 64'd0);
        check("stats reset rd_total", 64'(rd_total), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
